// File: rtl/demo_counter_gen.sv
// 20-bit counter generator: programmable step, lands on every magic value, wraps only through 20'hFFFFF.
// Optional feature: define DEMO_COUNTER_STEP_EN to honour `step`; otherwise the step is fixed at 1.
module demo_counter_gen #(
    parameter int STEP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [STEP_W-1:0] step,
    output logic [19:0]       counter,
    output logic              magic,
    output logic [2:0]        stage,
    output logic              done,
    output logic              wrap
);
    localparam logic [19:0] M0  = 20'd123456;
    localparam logic [19:0] M1  = 20'd234567;
    localparam logic [19:0] M2  = 20'd345678;
    localparam logic [19:0] M3  = 20'd456789;
    localparam logic [19:0] TOP = 20'hFFFFF;

    logic [20:0] s;
    logic [20:0] sum;
    logic [20:0] lim;
    logic [19:0] cnt_nxt;
    logic [19:0] stage_val;
    logic        at_top;
    logic        stage_hit;
    logic [2:0]  stage_nxt;
    logic        magic_nxt;

`ifdef DEMO_COUNTER_STEP_EN
    assign s = (step == '0) ? 21'd1 : 21'(step);
`else
    logic unused_step;
    assign unused_step = ^step;
    assign s = 21'd1;
`endif

    always_comb begin
        // Nearest magic value strictly above the current count caps the advance.
        lim = {1'b0, TOP};
        if (counter < M0)      lim = {1'b0, M0};
        else if (counter < M1) lim = {1'b0, M1};
        else if (counter < M2) lim = {1'b0, M2};
        else if (counter < M3) lim = {1'b0, M3};

        at_top = (counter == TOP);
        sum    = {1'b0, counter} + s;
        if (at_top)         cnt_nxt = '0;
        else if (sum > lim) cnt_nxt = lim[19:0];
        else                cnt_nxt = sum[19:0];

        case (stage)
            3'd0:    stage_val = M0;
            3'd1:    stage_val = M1;
            3'd2:    stage_val = M2;
            default: stage_val = M3;
        endcase
        stage_hit = (stage < 3'd4) && (cnt_nxt == stage_val);

        if (at_top)         stage_nxt = '0;
        else if (stage_hit) stage_nxt = stage + 3'd1;
        else                stage_nxt = stage;

        magic_nxt = (cnt_nxt == M0) || (cnt_nxt == M1) || (cnt_nxt == M2) || (cnt_nxt == M3);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter <= '0;
            magic   <= 1'b0;
            stage   <= '0;
            done    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            counter <= cnt_nxt;
            magic   <= magic_nxt;
            stage   <= stage_nxt;
            done    <= (stage_nxt == 3'd4);
            wrap    <= at_top;
        end
    end
endmodule

// File: tb/tb_demo_counter_gen.sv
// Directed bench for demo_counter_gen: vector table plus multi-cycle runs for clipping, wrap and reset.
module tb_demo_counter_gen;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  step  = '0;
    logic [19:0] counter;
    logic        magic;
    logic [2:0]  stage;
    logic        done;
    logic        wrap;

    int ncmp = 0;
    int nbad = 0;
    int mag[4] = '{123456, 234567, 345678, 456789};

    demo_counter_gen #(.STEP_W(8)) dut (
        .clock(clock), .reset(reset), .step(step), .counter(counter),
        .magic(magic), .stage(stage), .done(done), .wrap(wrap)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference next-count: walk the magic list for the first value above c.
    function automatic int ref_next(input int c, input int st);
        int lim;
        int n;
        if (c == 'hFFFFF) return 0;
        lim = 'hFFFFF;
        for (int i = 3; i >= 0; i--)
            if (mag[i] > c) lim = mag[i];
        n = c + ((st == 0) ? 1 : st);
        return (n > lim) ? lim : n;
    endfunction

    function automatic int is_magic(input int c);
        for (int i = 0; i < 4; i++)
            if (mag[i] == c) return 1;
        return 0;
    endfunction

    typedef struct {
        logic        rst;
        logic [7:0]  stp;
        int          cnt;
        logic        mg;
        int          stg;
        logic        dn;
        logic        wr;
    } vec_t;

`ifdef DEMO_COUNTER_STEP_EN
    localparam int S10 = 10;
`else
    localparam int S10 = 1;
`endif

    initial begin
        vec_t vt[9];
        int exp_cnt;
        int exp_stg;
        int budget;
        int hits;
        int st;

        vt[0] = '{1'b1, 8'd0,   0, 1'b0, 0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 8'd77,  0, 1'b0, 0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 8'd0,   1, 1'b0, 0, 1'b0, 1'b0};
        vt[3] = '{1'b0, 8'd0,   2, 1'b0, 0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 8'd0,   3, 1'b0, 0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 8'd10,  3 + S10, 1'b0, 0, 1'b0, 1'b0};
        vt[6] = '{1'b0, 8'd1,   4 + S10, 1'b0, 0, 1'b0, 1'b0};
        vt[7] = '{1'b1, 8'd3,   0, 1'b0, 0, 1'b0, 1'b0};
        vt[8] = '{1'b0, 8'd0,   1, 1'b0, 0, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            reset = vt[i].rst;
            step  = vt[i].stp;
            tick();
            chk($sformatf("vec%0d_counter", i), int'(counter), vt[i].cnt);
            chk($sformatf("vec%0d_magic", i),   int'(magic),   int'(vt[i].mg));
            chk($sformatf("vec%0d_stage", i),   int'(stage),   vt[i].stg);
            chk($sformatf("vec%0d_done", i),    int'(done),    int'(vt[i].dn));
            chk($sformatf("vec%0d_wrap", i),    int'(wrap),    int'(vt[i].wr));
        end

`ifdef DEMO_COUNTER_STEP_EN
        // step 200: clip onto M0 after 617 plain increments
        step = 8'd200;
        do_reset();
        repeat (617) tick();
        chk("s200_counter_617", int'(counter), 123400);
        chk("s200_magic_617", int'(magic), 0);
        tick();
        chk("s200_clip_counter", int'(counter), 123456);
        chk("s200_clip_magic", int'(magic), 1);
        chk("s200_clip_stage", int'(stage), 1);
        tick();
        chk("s200_after_counter", int'(counter), 123656);
        chk("s200_after_magic", int'(magic), 0);

        // step 255 through all four magic values, then steer onto 20'hFFF80
        step = 8'd255;
        do_reset();
        exp_cnt = 0;
        exp_stg = 0;
        hits    = 0;
        budget  = 8000;
        while (exp_cnt != 'hFFF80 && budget > 0) begin
            st = 255;
            if (exp_stg == 4 && ('hFFF80 - exp_cnt) < 255) st = 'hFFF80 - exp_cnt;
            step = 8'(st);
            tick();
            budget--;
            exp_cnt = ref_next(exp_cnt, st);
            if (exp_stg < 4 && exp_cnt == mag[exp_stg]) begin
                exp_stg++;
                hits++;
            end
            chk("run_counter", int'(counter), exp_cnt);
            chk("run_magic", int'(magic), is_magic(exp_cnt));
            chk("run_stage", int'(stage), exp_stg);
            chk("run_done", int'(done), int'(exp_stg == 4));
            chk("run_wrap", int'(wrap), 0);
        end
        chk("run_budget", int'(budget > 0), 1);
        chk("run_magic_hits", hits, 4);

        step = 8'd255;
        tick();
        chk("top_clip_counter", int'(counter), 'hFFFFF);
        chk("top_clip_wrap", int'(wrap), 0);
        chk("top_clip_done", int'(done), 1);
        tick();
        chk("wrap_counter", int'(counter), 0);
        chk("wrap_pulse", int'(wrap), 1);
        chk("wrap_stage", int'(stage), 0);
        chk("wrap_done", int'(done), 0);
        tick();
        chk("post_wrap_counter", int'(counter), 255);
        chk("post_wrap_pulse", int'(wrap), 0);

        // reset on the edge that would land on M1
        do_reset();
        exp_cnt = 0;
        budget  = 2000;
        while (ref_next(exp_cnt, 255) != mag[1] && budget > 0) begin
            tick();
            budget--;
            exp_cnt = ref_next(exp_cnt, 255);
        end
        chk("pre_m1_budget", int'(budget > 0), 1);
        chk("pre_m1_counter", int'(counter), exp_cnt);
        chk("pre_m1_stage", int'(stage), 1);
        reset = 1'b1;
        tick();
        chk("rst_m1_counter", int'(counter), 0);
        chk("rst_m1_magic", int'(magic), 0);
        chk("rst_m1_stage", int'(stage), 0);
        chk("rst_m1_done", int'(done), 0);
        chk("rst_m1_wrap", int'(wrap), 0);
        reset = 1'b0;
        tick();
        chk("rst_m1_release", int'(counter), 255);
`else
        // step ignored: strict +1 per cycle
        step = 8'd255;
        do_reset();
        for (int i = 1; i <= 1000; i++) begin
            tick();
            chk("inc1_counter", int'(counter), i);
            chk("inc1_magic", int'(magic), 0);
        end
        chk("inc1_stage", int'(stage), 0);
        reset = 1'b1;
        tick();
        chk("midrst_counter", int'(counter), 0);
        reset = 1'b0;
        tick();
        chk("midrst_release", int'(counter), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
